// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared types and grid constants for the move sequencer
package move_pkg;

  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 6;
  localparam int MAX_V_DEFAULT = GRID_ROWS - 1;
  localparam int MAX_H_DEFAULT = GRID_COLS - 1;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for one debounced button level
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic btnPrev;

  // Reset to 1 so a button held through reset is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) btnPrev <= 1'b1;
    else        btnPrev <= btn;
  end

  assign rise = btn & ~btnPrev;

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - paced multi-step grid move sequencer; MOVE_SEQ_REJECT_CNT_EN adds rejectCnt_o
module move_sequencer
  import move_pkg::*;
#(
  parameter int STEP_DIV    = 4,
  parameter int MAX_V_STEPS = MAX_V_DEFAULT,
  parameter int MAX_H_STEPS = MAX_H_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       upEnable_i,
  input  logic       downEnable_i,
  input  logic       leftEnable_i,
  input  logic       rightEnable_i,
  output logic [1:0] moveDir_o,
  output logic       step_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] stepCount_o
`ifdef MOVE_SEQ_REJECT_CNT_EN
  ,
  output logic [7:0] rejectCnt_o
`endif
);

  localparam logic [2:0] MAX_V     = 3'(MAX_V_STEPS);
  localparam logic [2:0] MAX_H     = 3'(MAX_H_STEPS);
  localparam logic [7:0] PACE_LOAD = 8'(STEP_DIV - 1);

  logic   riseUp, riseDown, riseLeft, riseRight;
  logic   accept, dirEnable, maxReached;
  dir_e   acceptDir, dir;
  state_e state, stateNext;
  logic [7:0] paceCnt;
  logic [2:0] stepCnt, maxSteps;

  btn_edge uEdgeUp    (.clk(clk), .rst_n(rst_n), .btn(btnUp),    .rise(riseUp));
  btn_edge uEdgeDown  (.clk(clk), .rst_n(rst_n), .btn(btnDown),  .rise(riseDown));
  btn_edge uEdgeLeft  (.clk(clk), .rst_n(rst_n), .btn(btnLeft),  .rise(riseLeft));
  btn_edge uEdgeRight (.clk(clk), .rst_n(rst_n), .btn(btnRight), .rise(riseRight));

  always_comb begin
    accept    = 1'b1;
    acceptDir = UP;
    if (riseUp && upEnable_i)              acceptDir = UP;
    else if (riseDown && downEnable_i)     acceptDir = DOWN;
    else if (riseLeft && leftEnable_i)     acceptDir = LEFT;
    else if (riseRight && rightEnable_i)   acceptDir = RIGHT;
    else                                   accept    = 1'b0;
  end

  always_comb begin
    dirEnable = 1'b0;
    case (dir)
      UP:      dirEnable = upEnable_i;
      DOWN:    dirEnable = downEnable_i;
      LEFT:    dirEnable = leftEnable_i;
      default: dirEnable = rightEnable_i;
    endcase
  end

  assign maxSteps   = (dir == UP || dir == DOWN) ? MAX_V : MAX_H;
  assign maxReached = (stepCnt >= maxSteps);

  // Once the axis limit is hit no further step can follow, so the move closes
  // after a single WAIT cycle instead of pacing out a full interval.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = STEP;
      STEP: stateNext = WAIT;
      WAIT: begin
        if (maxReached)         stateNext = DONE;
        else if (paceCnt <= 8'd1) stateNext = dirEnable ? STEP : DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir     <= UP;
      stepCnt <= 3'd0;
      paceCnt <= 8'd0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (accept) begin
          dir     <= acceptDir;
          stepCnt <= 3'd0;
        end
        STEP: begin
          stepCnt <= stepCnt + 3'd1;
          paceCnt <= PACE_LOAD;
        end
        WAIT: if (paceCnt != 8'd0) paceCnt <= paceCnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign moveDir_o   = dir;
  assign step_o      = (state == STEP);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign stepCount_o = stepCnt;

`ifdef MOVE_SEQ_REJECT_CNT_EN
  logic       anyRise;
  logic [7:0] rejectCnt;

  assign anyRise = riseUp | riseDown | riseLeft | riseRight;

  // Only edges refused in IDLE count; edges swallowed while busy do not.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rejectCnt <= 8'd0;
    else if (state == IDLE && anyRise && !accept && rejectCnt != 8'hFF)
      rejectCnt <= rejectCnt + 8'd1;
  end

  assign rejectCnt_o = rejectCnt;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench for move_sequencer
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnUp, btnDown, btnLeft, btnRight;
  logic       upEnable_i, downEnable_i, leftEnable_i, rightEnable_i;
  logic [1:0] moveDir_o;
  logic       step_o, busy_o, done_o;
  logic [2:0] stepCount_o;
`ifdef MOVE_SEQ_REJECT_CNT_EN
  logic [7:0] rejectCnt_o;
`endif

  move_sequencer #(.STEP_DIV(4), .MAX_V_STEPS(5), .MAX_H_STEPS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .upEnable_i(upEnable_i), .downEnable_i(downEnable_i),
    .leftEnable_i(leftEnable_i), .rightEnable_i(rightEnable_i),
    .moveDir_o(moveDir_o), .step_o(step_o), .busy_o(busy_o), .done_o(done_o),
    .stepCount_o(stepCount_o)
`ifdef MOVE_SEQ_REJECT_CNT_EN
    , .rejectCnt_o(rejectCnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit isDone;
    int at;
    int dir;
    int cnt;
  } ev_t;

  ev_t sbQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;

  task automatic check(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickTo(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pushEv(input bit isDone, input int at, input int dir, input int cnt);
    ev_t e;
    e.isDone = isDone; e.at = at; e.dir = dir; e.cnt = cnt;
    sbQ.push_back(e);
  endtask

  // Full move expectation: step k shows the pre-increment count k-1.
  task automatic pushMove(input int c0, input int dir, input int nSteps, input int doneAt);
    for (int k = 0; k < nSteps; k++) pushEv(1'b0, c0 + 1 + 4 * k, dir, k);
    pushEv(1'b1, c0 + doneAt, dir, nSteps);
  endtask

  task automatic checkDrained(input string name);
    check(name, sbQ.size(), 0);
    sbQ.delete();
  endtask

  // Monitor: every step/done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (step_o || done_o)) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("FAIL unexpected_pulse: step=%0d done=%0d at cycle %0d, expected none",
                 step_o, done_o, cyc);
      end else begin
        ev_t e;
        e = sbQ.pop_front();
        check("pulse_kind", int'(done_o), int'(e.isDone));
        check("pulse_cycle", cyc, e.at);
        check("pulse_dir", int'(moveDir_o), e.dir);
        check("pulse_count", int'(stepCount_o), e.cnt);
      end
    end
  end

  int c0;

  initial begin
    rst_n = 1'b0;
    {btnUp, btnDown, btnLeft, btnRight} = 4'b0;
    {upEnable_i, downEnable_i, leftEnable_i, rightEnable_i} = 4'b0;
    tick(); tick();
    check("rst_busy", int'(busy_o), 0);
    check("rst_step", int'(step_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_dir", int'(moveDir_o), 0);
    check("rst_count", int'(stepCount_o), 0);
`ifdef MOVE_SEQ_REJECT_CNT_EN
    check("rst_reject", int'(rejectCnt_o), 0);
`endif
    rst_n = 1'b1;
    tick(); tick();

    // Up move, 5 steps; a down edge landing in the DONE cycle is ignored.
    upEnable_i = 1'b1;
    btnUp = 1'b1; c0 = cyc;
    pushMove(c0, 0, 5, 19);
    tick(); btnUp = 1'b0;
    tickTo(c0 + 19);
    downEnable_i = 1'b1; btnDown = 1'b1;
    tickTo(c0 + 30);
    btnDown = 1'b0;
    check("up_busy_after", int'(busy_o), 0);
    check("up_count", int'(stepCount_o), 5);
    check("up_dir_kept", int'(moveDir_o), 0);
    checkDrained("up_drained");
    downEnable_i = 1'b0; upEnable_i = 1'b0;

    // Left move, 3 steps.
    leftEnable_i = 1'b1;
    btnLeft = 1'b1; c0 = cyc;
    pushMove(c0, 2, 3, 11);
    tick(); btnLeft = 1'b0;
    tickTo(c0 + 20);
    check("left_count", int'(stepCount_o), 3);
    checkDrained("left_drained");
    leftEnable_i = 1'b0;

    // Right move with the enable dropping after the second step.
    rightEnable_i = 1'b1;
    btnRight = 1'b1; c0 = cyc;
    pushEv(1'b0, c0 + 1, 3, 0);
    pushEv(1'b0, c0 + 5, 3, 1);
    pushEv(1'b1, c0 + 9, 3, 2);
    tick(); btnRight = 1'b0;
    tickTo(c0 + 6); rightEnable_i = 1'b0;
    tickTo(c0 + 20);
    check("right_count", int'(stepCount_o), 2);
    checkDrained("right_drained");

    // Simultaneous up+left, up disabled: left wins.
    leftEnable_i = 1'b1;
    btnUp = 1'b1; btnLeft = 1'b1; c0 = cyc;
    pushMove(c0, 2, 3, 11);
    tick(); btnUp = 1'b0; btnLeft = 1'b0;
    check("prio_left_dir", int'(moveDir_o), 2);
    tickTo(c0 + 20);
    checkDrained("prio_left_drained");

    // Simultaneous up+left, both enabled: up wins; a left edge mid-move is ignored.
    upEnable_i = 1'b1;
    btnUp = 1'b1; btnLeft = 1'b1; c0 = cyc;
    pushMove(c0, 0, 5, 19);
    tick(); btnUp = 1'b0; btnLeft = 1'b0;
    check("prio_up_dir", int'(moveDir_o), 0);
    tickTo(c0 + 6); btnLeft = 1'b1;
    tick(); btnLeft = 1'b0;
    tickTo(c0 + 30);
    check("prio_up_count", int'(stepCount_o), 5);
    check("prio_up_dir_end", int'(moveDir_o), 0);
    checkDrained("prio_up_drained");
    upEnable_i = 1'b0; leftEnable_i = 1'b0;

    // Rejected down edge: nothing moves, last count holds.
    btnDown = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reject_busy", int'(busy_o), 0);
    end
    check("reject_count_hold", int'(stepCount_o), 5);
`ifdef MOVE_SEQ_REJECT_CNT_EN
    check("reject_cnt_1", int'(rejectCnt_o), 1);
`endif
    btnDown = 1'b0; tick();
    for (int i = 0; i < 300; i++) begin
      btnDown = 1'b1; tick();
      btnDown = 1'b0; tick();
    end
`ifdef MOVE_SEQ_REJECT_CNT_EN
    check("reject_cnt_sat", int'(rejectCnt_o), 255);
`endif
    check("reject_many_busy", int'(busy_o), 0);
    checkDrained("reject_drained");

    // Reset during WAIT with the button held through reset.
    upEnable_i = 1'b1;
    btnUp = 1'b1; c0 = cyc;
    pushEv(1'b0, c0 + 1, 0, 0);
    tickTo(c0 + 2);
    check("midrst_busy_before", int'(busy_o), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_step", int'(step_o), 0);
    check("midrst_done", int'(done_o), 0);
    check("midrst_dir", int'(moveDir_o), 0);
    check("midrst_count", int'(stepCount_o), 0);
`ifdef MOVE_SEQ_REJECT_CNT_EN
    check("midrst_reject", int'(rejectCnt_o), 0);
`endif
    tickTo(c0 + 30);
    check("held_no_move_busy", int'(busy_o), 0);
    check("held_no_move_count", int'(stepCount_o), 0);
    checkDrained("midrst_drained");
    btnUp = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
